uart_tx_sched: RTL and testbench
================================

UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the serial line.
REQ-002 Parameter BAUD_DIV, default 301: CLOCK_50 cycles per 16x-oversample tick, so one bit period is BIT_CYCLES = 16*BAUD_DIV cycles.
REQ-003 Port CLOCK_50, input, 1: sole clock, rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port req, input, NREQ: bit i high means requester i has a byte pending.
REQ-006 Port DataIn, input, 8*NREQ: byte i is DataIn[8i+7:8i].
REQ-007 Port grant, output, NREQ: one-hot, one-cycle pulse when a requester's byte is accepted.
REQ-008 Port DataOut, output, 1: serial TX line, idle high.
REQ-009 Port busy, output, 1: high whenever a frame is in progress (any state other than IDLE).

Function
REQ-010 The FSM SHALL have exactly four states: IDLE, START, DATA and STOP.
REQ-011 In IDLE with req nonzero, the block SHALL on the next edge:
- pulse grant for the selected requester;
- latch that requester's byte;
- clear the bit timer;
- enter START.
REQ-012 Selection SHALL be round-robin: the search starts at last_granted+1 modulo NREQ; the first set req bit wins.
REQ-013 START SHALL drive DataOut low for exactly BIT_CYCLES cycles.
REQ-014 DATA SHALL shift the latched byte out LSB first, each bit for exactly BIT_CYCLES cycles, with a 3-bit index counting 0..7.
REQ-015 STOP SHALL drive DataOut high for exactly BIT_CYCLES cycles, then return to IDLE.
REQ-016 A full frame SHALL be exactly 10*BIT_CYCLES cycles, measured from the first cycle of START.
REQ-017 IDLE SHALL occupy at least one cycle between frames, so back-to-back frames have a gap of exactly 1 cycle.
REQ-018 req and DataIn are sampled only in IDLE:
- changes during a frame have no effect;
- a req dropped before grant is treated as withdrawn.
REQ-019 A requester SHALL deassert req in the cycle after its grant, or it is re-arbitrated normally.
REQ-020 grant SHALL be zero in every cycle except the IDLE-to-START transition.
REQ-021 DataOut SHALL be a registered output, glitch-free at bit boundaries.
REQ-022 The bit timer SHALL count with sufficient width for BIT_CYCLES-1 and wrap to 0 at each bit boundary.

Reset
REQ-023 Asserting reset SHALL immediately, regardless of state (including mid-frame), force:
- IDLE;
- DataOut = 1, busy = 0, grant = 0;
- bit timer = 0, bit index = 0;
- last_granted = NREQ-1, so requester 0 has first priority.
REQ-024 After reset deasserts, the first grant SHALL occur no earlier than the first rising edge with req nonzero.

Structure
REQ-025 A shared package SHALL hold the state enum (IDLE, START, DATA, STOP), the frame-length constants (8 data bits, 1 start bit, 1 stop bit) and the BIT_CYCLES function.
REQ-026 Bit timing SHALL live in one sub-module, uart_bit_timer, which:
- takes a clear input and produces a one-cycle bit_done pulse every BIT_CYCLES cycles;
- has asynchronous active-high reset.
REQ-027 The round-robin selector SHALL be combinational logic inside uart_tx_sched.

Verification (BAUD_DIV = 1, so BIT_CYCLES = 16)
REQ-028 Single frame: req = 0001, byte0 = 0x55. Required response:
- grant = 0001 for one cycle;
- DataOut sequence is 0,1,0,1,0,1,0,1,0,1, each bit held 16 cycles;
- busy is high for 160 cycles.
REQ-029 Round-robin: req = 1111 held continuously. Grants SHALL occur in order 0001, 0010, 0100, 1000, 0001, with successive grants spaced 161 cycles apart.
REQ-030 Skip: after requester 1 is granted, req = 0001. The next grant SHALL be 0001, not a stall.
REQ-031 Reset mid-frame: assert reset during DATA bit 3 of byte 0xA3. Required response:
- DataOut = 1 and busy = 0 within the same cycle;
- the next frame with req = 0100 is granted to requester 2 first, with a clean start bit.
REQ-032 Stability: change DataIn and req during DATA of a frame carrying byte 0x0F. The transmitted bits SHALL remain 1,1,1,1,0,0,0,0 (LSB first).

Source files
------------

// File: rtl/uart_tx_sched_pkg.sv
// uart_tx_sched_pkg
//   Shared definitions for the multi-requester UART transmitter:
//   FSM state encoding, frame-shape constants and the bit-period helper.
package uart_tx_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int DATA_BITS  = 8;
    localparam int START_BITS = 1;
    localparam int STOP_BITS  = 1;
    localparam int FRAME_BITS = START_BITS + DATA_BITS + STOP_BITS;
    localparam int OVERSAMPLE = 16;

    // Clock cycles per serial bit for a given 16x-oversample divider.
    function automatic int bit_cycles(input int baud_div);
        return OVERSAMPLE * baud_div;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer
//   Free-running bit-period counter. While clear_i is high the count is held
//   at zero; otherwise it counts 0..BIT_CYCLES-1 and wraps, pulsing
//   bit_done_o for one cycle in the last cycle of every bit period.
// Ports:
//   clk_i      - clock, rising edge
//   rst_i      - asynchronous active-high reset (count -> 0)
//   clear_i    - hold the count at zero
//   bit_done_o - one-cycle pulse in the final cycle of each bit period
module uart_bit_timer #(
    parameter int BIT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    output logic bit_done_o
);

    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q + CW'(1);
        if (clear_i || (count_q == LAST)) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bit_done_o = !clear_i && (count_q == LAST);

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched
//   Round-robin scheduler in front of a single 8N1 UART transmitter.
//   NREQ requesters share one serial line; one byte is taken per frame.
// Ports:
//   CLOCK_50 - clock, rising edge
//   reset    - asynchronous active-high reset
//   req      - per-requester "byte pending" flags
//   DataIn   - packed bytes, requester i at DataIn[8i+7:8i]
//   grant    - one-hot, one-cycle acceptance pulse
//   DataOut  - registered serial line, idle high
//   busy     - high while a frame is in progress
//   state_o  - current FSM state (debug visibility)
//
// Handshake: a requester holds req[i] high with its byte stable on DataIn.
// req/DataIn are only sampled in IDLE; the byte is taken on the edge that
// leaves IDLE, and grant[i] is high for exactly the following cycle. The
// requester must drop req[i] in that cycle or it will be arbitrated again
// at the next IDLE.
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int BAUD_DIV = 301
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] DataIn,
    output logic [NREQ-1:0]   grant,
    output logic              DataOut,
    output logic              busy,
    output logic [1:0]        state_o
);

    localparam int BIT_CYCLES = bit_cycles(BAUD_DIV);
    localparam int IDXW       = (NREQ > 1) ? $clog2(NREQ) : 1;

    tx_state_t       state_q, state_d;
    logic [IDXW-1:0] last_q, last_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic            dout_q, dout_d;
    logic [NREQ-1:0] grant_q, grant_d;

    logic            bit_done;
    logic            sel_valid;
    logic [IDXW-1:0] sel_idx;
    logic [7:0]      sel_byte;

    // The timer is held at zero throughout IDLE, so the first START cycle
    // always begins a fresh bit period.
    uart_bit_timer #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_bit_timer (
        .clk_i     (CLOCK_50),
        .rst_i     (reset),
        .clear_i   (state_q == IDLE),
        .bit_done_o(bit_done)
    );

    // Round-robin pick: scan from last_q+1 upward, wrapping, first set bit wins.
    always_comb begin
        int cand;
        cand      = 0;
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = (int'(last_q) + off) % NREQ;
            if (!sel_valid && req[IDXW'(cand)]) begin
                sel_valid = 1'b1;
                sel_idx   = IDXW'(cand);
            end
        end
    end

    always_comb begin
        sel_byte = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel_idx == IDXW'(i)) begin
                sel_byte = DataIn[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        dout_d    = dout_q;
        grant_d   = '0;
        case (state_q)
            IDLE: begin
                dout_d = 1'b1;
                if (sel_valid) begin
                    grant_d[sel_idx] = 1'b1;
                    last_d           = sel_idx;
                    shreg_d          = sel_byte;
                    bit_idx_d        = '0;
                    dout_d           = 1'b0;
                    state_d          = START;
                end
            end
            START: begin
                if (bit_done) begin
                    // Present bit 0 and pre-shift so shreg_q[0] is always the next bit.
                    dout_d    = shreg_q[0];
                    shreg_d   = {1'b0, shreg_q[7:1]};
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                        dout_d  = 1'b1;
                        state_d = STOP;
                    end else begin
                        dout_d    = shreg_q[0];
                        shreg_d   = {1'b0, shreg_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            last_q    <= IDXW'(NREQ - 1);
            shreg_q   <= '0;
            bit_idx_q <= '0;
            dout_q    <= 1'b1;
            grant_q   <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            dout_q    <= dout_d;
            grant_q   <= grant_d;
        end
    end

    assign grant   = grant_q;
    assign DataOut = dout_q;
    assign busy    = (state_q != IDLE);
    assign state_o = state_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched
//   Directed bench for uart_tx_sched with NREQ=4, BAUD_DIV=1 (16-cycle bits).
//   The driver pushes expected grants, bytes and busy lengths into queues;
//   independent monitors pop and compare when the DUT produces them.
module tb_uart_tx_sched;

  logic        CLOCK_50;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] DataIn;
  logic [3:0]  grant;
  logic        DataOut;
  logic        busy;
  logic [1:0]  state_o;

  int checks_total  = 0;
  int checks_passed = 0;
  int cyc           = 0;

  // grant queue entry: {expected gap since previous grant (0 = unchecked), grant}
  logic [19:0] exp_grant_q[$];
  logic [7:0]  exp_byte_q[$];
  logic [15:0] exp_busy_q[$];

  uart_tx_sched #(
    .NREQ(4),
    .BAUD_DIV(1)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .req     (req),
    .DataIn  (DataIn),
    .grant   (grant),
    .DataOut (DataOut),
    .busy    (busy),
    .state_o (state_o)
  );

  // clock / reset block
  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  function automatic void fail(input string name, input logic [31:0] act);
    checks_total++;
    $display("FAIL %s: got 0x%0h, expected no output", name, act);
  endfunction

  // driver tasks
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic expect_frame(input logic [3:0] g, input logic [15:0] gap, input logic [7:0] b);
    exp_grant_q.push_back({gap, g});
    exp_byte_q.push_back(b);
    exp_busy_q.push_back(16'd160);
  endtask

  task automatic set_byte(input int idx, input logic [7:0] b);
    DataIn[8*idx +: 8] = b;
  endtask

  // grant monitor
  initial begin : grant_mon
    int last_cyc;
    logic [19:0] e;
    last_cyc = 0;
    forever begin
      @(negedge CLOCK_50);
      if (grant !== 4'b0000) begin
        if (exp_grant_q.size() == 0) begin
          fail("unexpected_grant", 32'(grant));
        end else begin
          e = exp_grant_q.pop_front();
          check("grant", 32'(grant), 32'(e[3:0]));
          if (e[19:4] != 16'd0) check("grant_gap", 32'(cyc - last_cyc), 32'(e[19:4]));
        end
        last_cyc = cyc;
      end
    end
  end

  // busy-length monitor
  initial begin : busy_mon
    int busy_len;
    busy_len = 0;
    forever begin
      @(negedge CLOCK_50);
      if (reset) begin
        busy_len = 0;
      end else if (busy === 1'b1) begin
        busy_len++;
      end else if (busy_len != 0) begin
        if (exp_busy_q.size() == 0) fail("unexpected_busy", 32'(busy_len));
        else check("busy_len", 32'(busy_len), 32'(exp_busy_q.pop_front()));
        busy_len = 0;
      end
    end
  end

  // serial receiver: each bit must hold its first-cycle value for all 16 cycles
  initial begin : rx_mon
    logic       active;
    logic       stable;
    logic [9:0] bits;
    int         c;
    active = 1'b0;
    stable = 1'b1;
    bits   = '0;
    c      = 0;
    forever begin
      @(negedge CLOCK_50);
      if (reset) begin
        active = 1'b0;
      end else if (!active) begin
        if (DataOut === 1'b0) begin
          active = 1'b1;
          c      = 0;
          bits   = '0;
          stable = 1'b1;
        end
      end else begin
        c++;
        if (c % 16 == 0) bits[c/16] = DataOut;
        else if (DataOut !== bits[c/16]) stable = 1'b0;
        if (c == 159) begin
          check("stop_bit", 32'(bits[9]), 32'd1);
          check("bit_timing", 32'(stable), 32'd1);
          if (exp_byte_q.size() == 0) fail("unexpected_frame", 32'(bits[8:1]));
          else check("frame_byte", 32'(bits[8:1]), 32'(exp_byte_q.pop_front()));
          active = 1'b0;
        end
      end
    end
  end

  // stimulus
  initial begin
    reset  = 1'b1;
    req    = 4'b0000;
    DataIn = 32'h0;
    wait_cycles(3);
    check("rst_dataout", 32'(DataOut), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_state", 32'(state_o), 32'd0);
    reset = 1'b0;
    wait_cycles(4);

    // single frame, 0x55 from requester 0
    set_byte(0, 8'h55);
    expect_frame(4'b0001, 16'd0, 8'h55);
    req = 4'b0001;
    wait_cycles(1);
    req = 4'b0000;
    wait_cycles(170);

    // round robin from reset priority, all requesting
    reset = 1'b1;
    wait_cycles(2);
    reset = 1'b0;
    wait_cycles(2);
    DataIn = {8'h88, 8'h44, 8'h22, 8'h11};
    expect_frame(4'b0001, 16'd0,   8'h11);
    expect_frame(4'b0010, 16'd161, 8'h22);
    expect_frame(4'b0100, 16'd161, 8'h44);
    expect_frame(4'b1000, 16'd161, 8'h88);
    expect_frame(4'b0001, 16'd161, 8'h11);
    req = 4'b1111;
    wait_cycles(645);
    req = 4'b0000;
    wait_cycles(170);

    // skip: requester 1 then only requester 0 pending
    set_byte(1, 8'h3C);
    set_byte(0, 8'hE1);
    expect_frame(4'b0010, 16'd0,   8'h3C);
    expect_frame(4'b0001, 16'd161, 8'hE1);
    req = 4'b0010;
    wait_cycles(1);
    req = 4'b0001;
    wait_cycles(161);
    req = 4'b0000;
    wait_cycles(170);

    // stability: inputs disturbed mid-frame
    set_byte(3, 8'h0F);
    expect_frame(4'b1000, 16'd0, 8'h0F);
    req = 4'b1000;
    wait_cycles(1);
    req = 4'b0000;
    wait_cycles(40);
    DataIn = {8'hF0, 8'hAA, 8'h55, 8'h00};
    req = 4'b0111;
    wait_cycles(60);
    req = 4'b0000;
    wait_cycles(80);

    // reset during DATA bit 3 of 0xA3
    set_byte(1, 8'hA3);
    exp_grant_q.push_back({16'd0, 4'b0010});
    req = 4'b0010;
    wait_cycles(1);
    req = 4'b0000;
    wait_cycles(69);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_dataout", 32'(DataOut), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_grant", 32'(grant), 32'd0);
    check("midrst_state", 32'(state_o), 32'd0);
    wait_cycles(2);
    reset = 1'b0;
    wait_cycles(3);
    set_byte(2, 8'hC6);
    expect_frame(4'b0100, 16'd0, 8'hC6);
    req = 4'b0100;
    wait_cycles(1);
    req = 4'b0000;
    wait_cycles(170);

    // final report
    check("grants_left", 32'(exp_grant_q.size()), 32'd0);
    check("bytes_left", 32'(exp_byte_q.size()), 32'd0);
    check("busy_left", 32'(exp_busy_q.size()), 32'd0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
